norm_left_shift: RTL
====================

// Module: norm_left_shift
// PURPOSE
//  Post-add normaliser for the 32-bit FP adder datapath; inverse direction of the alignment right shifter.
//  Takes the 28-bit raw sum {C,H,F[22:0],G,R,S} and moves the leading one to the hidden-bit position (bit 26).
//  Left-shifts by the leading-zero count and decrements the exponent, or right-shifts by 1 on carry-out and
//  increments it. Two-stage valid/ready pipeline that sits between the mantissa adder and the rounder.
// PARAMETERS
//  MW   28  mantissa width incl. carry, hidden, fraction, G/R/S (bit MW-2 = hidden position)
//  EW   8   biased exponent width; EMAX = 2**EW-1 = 255
// PORTS
//  clk        in   1    clock, all state on rising edge
//  rst_n      in   1    synchronous reset, active low
//  in_valid   in   1    input beat valid
//  in_ready   out  1    block can accept beat this cycle
//  in_sign    in   1    sign, passed through unchanged
//  in_exp     in   EW   biased exponent of unnormalised sum (larger operand's exponent)
//  in_mant    in   MW   raw sum {C,H,F,G,R,S}
//  out_valid  out  1    output beat valid
//  out_ready  in   1    downstream accepts beat
//  out_sign   out  1    sign
//  out_exp    out  EW   adjusted exponent (0 = subnormal/zero, 255 = overflow)
//  out_mant   out  MW   normalised mantissa, bit MW-1 always 0
//  out_zero   out  1    exact-zero result
//  out_ovf    out  1    exponent overflow to infinity
// BEHAVIOUR
//  Reset: one clock with rst_n=0 clears s1_valid, s2_valid; out_valid=0, out_exp=0, out_mant=0, out_sign=0,
//   out_zero=0, out_ovf=0; in_ready=1 on the first cycle after reset. Reset mid-flight discards both stages.
//  Handshake: transfer on valid&ready at each boundary. s2_adv = !s2_valid | out_ready;
//   s1_adv = !s1_valid | s2_adv; in_ready = s1_adv (combinational). Output fields held stable while
//   out_valid & !out_ready. Latency 2 cycles; throughput 1 beat/cycle when out_ready=1.
//  Stage 1 (register): sign, exp, mant, carry=mant[MW-1], zero=(mant==0), lz = leading zeros of mant[MW-2:0]
//   (0..MW-1; MW-1 only when zero).
//  Stage 2 (register output), priority order:
//   1 zero: out_mant=0, out_exp=0, out_zero=1, out_ovf=0.
//   2 carry: mant>>1 with new bit0 = mant[1]|mant[0] (sticky preserved); e=exp+1 in EW+1 bits;
//     if e>=EMAX: out_exp=EMAX, out_mant=0, out_ovf=1; else out_exp=e.
//   3 else: sa = (exp==0) ? 0 : min(lz, exp-1); out_mant = mant<<sa (zero fill from LSB);
//     out_exp = (out_mant[MW-2]==1) ? exp-sa : 0  (exponent clamps to subnormal, never wraps below 0).
//  Shift amounts >= MW cannot occur (lz<=MW-2 when non-zero); shifter still yields 0 for sa>=MW.
//  Simultaneous in/out handshakes in same cycle: stage contents move forward, no bubble, no drop.
//  in_exp=EMAX inputs are not produced upstream; behaviour: treated as overflow path via rule 2/3 math.
// STRUCTURE
//  Shared package fp_add_pkg: MW, EW, EMAX, HID_BIT=MW-2, mantissa/exponent typedefs.
//  One sub-module: lzc_27 (combinational leading-zero counter, 27-bit in, 5-bit count, all-zero flag),
//   instantiated in stage 1. Left shift and exponent adjust inline in stage 2.
// TESTING
//  1 Reset: hold rst_n=0 with in_valid=1 -> out_valid=0, in_ready=1 after release, all outputs 0.
//  2 Carry: exp=8'd127, mant=28'h8000003 -> out_exp=128, out_mant=28'h4000001 (sticky from bits 1:0).
//  3 Cancellation: exp=100, mant=28'h0000100 (lz=18) -> out_mant=28'h4000000, out_exp=82.
//  4 Subnormal clamp: exp=3, mant=28'h0010000 (lz=10) -> sa=2, out_mant=28'h0040000, out_exp=0;
//    and mant=0, exp=50 -> out_zero=1, out_exp=0.
//  5 Overflow: exp=254, mant=28'h8000000 -> out_exp=255, out_mant=0, out_ovf=1.
//  6 Backpressure: stream 5 beats, out_ready=0 for 3 cycles mid-stream -> in_ready drops after 2 held
//    beats, outputs stable while stalled, all 5 beats emerge in order, none duplicated or lost;
//    with out_ready=1 back-to-back beats appear 2 cycles after acceptance, one per cycle.

Source files
------------

// File: rtl/fp_add_pkg.sv
// rtl/fp_add_pkg.sv - shared widths and types for the FP adder datapath
//
// Purpose: single home for the mantissa/exponent widths used by the
// post-add normaliser and its leading-zero counter.
// Ports: none (package).

package fp_add_pkg;

   localparam int MW      = 28;              // {C,H,F[22:0],G,R,S}
   localparam int EW      = 8;               // biased exponent width
   localparam int EMAX    = (1 << EW) - 1;   // all-ones exponent = infinity
   localparam int HID_BIT = MW - 2;          // hidden-bit position
   localparam int LZW     = 5;               // enough for counts 0..MW-1

   typedef logic [MW-1:0]  mant_t;
   typedef logic [EW-1:0]  exp_t;
   typedef logic [LZW-1:0] lz_t;

endpackage

// File: rtl/lzc_27.sv
// rtl/lzc_27.sv - combinational leading-zero counter over the 27 bits below the carry
//
// Purpose: counts leading zeros of {H,F,G,R,S}; count is 27 only when all-zero.
// Ports:
//   i_data  in   27  value to scan, bit 26 is the most significant
//   o_count out  5   number of zeros above the leading one
//   o_zero  out  1   i_data is all zeros

module lzc_27
   import fp_add_pkg::*;
(
   input  logic [HID_BIT:0] i_data,
   output lz_t              o_count,
   output logic             o_zero
);

   // Scan upward so the highest set bit is the last one to write the count.
   always_comb begin
      o_count = LZW'(HID_BIT + 1);
      o_zero  = (i_data == '0);
      for (int i = 0; i <= HID_BIT; i++) begin
         if (i_data[i]) begin
            o_count = LZW'(HID_BIT - i);
         end
      end
   end

endmodule

// File: rtl/norm_left_shift.sv
// rtl/norm_left_shift.sv - two-stage post-add normaliser with valid/ready handshake
//
// Purpose: moves the leading one of the raw sum to the hidden-bit position,
// adjusting the exponent; right-shifts by one on carry-out, left-shifts by the
// leading-zero count (clamped to subnormal) otherwise.
// Ports:
//   clk        in   1   clock
//   rst_n      in   1   synchronous reset, active low
//   in_valid   in   1   input beat valid
//   in_ready   out  1   block accepts a beat this cycle
//   in_sign    in   1   sign, passed through
//   in_exp     in   EW  biased exponent of the unnormalised sum
//   in_mant    in   MW  raw sum {C,H,F,G,R,S}
//   out_valid  out  1   output beat valid
//   out_ready  in   1   downstream accepts the beat
//   out_sign   out  1   sign
//   out_exp    out  EW  adjusted exponent
//   out_mant   out  MW  normalised mantissa, top bit always 0
//   out_zero   out  1   exact-zero result
//   out_ovf    out  1   exponent overflowed to infinity

module norm_left_shift
   import fp_add_pkg::*;
(
   input  logic  clk,
   input  logic  rst_n,
   input  logic  in_valid,
   output logic  in_ready,
   input  logic  in_sign,
   input  exp_t  in_exp,
   input  mant_t in_mant,
   output logic  out_valid,
   input  logic  out_ready,
   output logic  out_sign,
   output exp_t  out_exp,
   output mant_t out_mant,
   output logic  out_zero,
   output logic  out_ovf
);

   // stage 1 registers
   logic  r_s1_valid;
   logic  r_s1_sign;
   exp_t  r_s1_exp;
   mant_t r_s1_mant;
   logic  r_s1_carry;
   logic  r_s1_zero;
   lz_t   r_s1_lz;

   // stage 2 (output) registers
   logic  r_s2_valid;
   logic  r_out_sign;
   exp_t  r_out_exp;
   mant_t r_out_mant;
   logic  r_out_zero;
   logic  r_out_ovf;

   logic  w_s1_adv;
   logic  w_s2_adv;
   lz_t   w_lz_count;
   logic  w_lz_zero;

   logic [EW:0] w_exp_inc;
   exp_t  w_exp_m1;
   exp_t  w_lz_ext;
   exp_t  w_sa;
   mant_t w_shl;
   exp_t  w_nxt_exp;
   mant_t w_nxt_mant;
   logic  w_nxt_zero;
   logic  w_nxt_ovf;

   assign w_s2_adv = !r_s2_valid | out_ready;
   assign w_s1_adv = !r_s1_valid | w_s2_adv;
   assign in_ready = w_s1_adv;

   lzc_27 u_lzc (
      .i_data  (in_mant[HID_BIT:0]),
      .o_count (w_lz_count),
      .o_zero  (w_lz_zero)
   );

   always_comb begin
      w_exp_inc = {1'b0, r_s1_exp} + (EW+1)'(1);
      w_exp_m1  = r_s1_exp - exp_t'(1);
      w_lz_ext  = exp_t'(r_s1_lz);

      // Never shift further than the exponent can absorb: stop at exponent 1,
      // which becomes the subnormal encoding if the hidden bit is still clear.
      if (r_s1_exp == '0) begin
         w_sa = '0;
      end else if (w_lz_ext < w_exp_m1) begin
         w_sa = w_lz_ext;
      end else begin
         w_sa = w_exp_m1;
      end
      w_shl = r_s1_mant << w_sa;

      w_nxt_zero = 1'b0;
      w_nxt_ovf  = 1'b0;
      w_nxt_mant = w_shl;
      w_nxt_exp  = w_shl[HID_BIT] ? (r_s1_exp - w_sa) : '0;

      if (r_s1_zero) begin
         w_nxt_mant = '0;
         w_nxt_exp  = '0;
         w_nxt_zero = 1'b1;
      end else if (r_s1_carry) begin
         if (w_exp_inc >= (EW+1)'(EMAX)) begin
            w_nxt_exp  = exp_t'(EMAX);
            w_nxt_mant = '0;
            w_nxt_ovf  = 1'b1;
         end else begin
            w_nxt_exp  = w_exp_inc[EW-1:0];
            // Dropped bit 0 folds into the new sticky bit.
            w_nxt_mant = {1'b0, r_s1_mant[MW-1:2], r_s1_mant[1] | r_s1_mant[0]};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s2_valid <= 1'b0;
         r_out_sign <= 1'b0;
         r_out_exp  <= '0;
         r_out_mant <= '0;
         r_out_zero <= 1'b0;
         r_out_ovf  <= 1'b0;
      end else begin
         if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
               r_s1_sign  <= in_sign;
               r_s1_exp   <= in_exp;
               r_s1_mant  <= in_mant;
               r_s1_carry <= in_mant[MW-1];
               r_s1_zero  <= w_lz_zero & !in_mant[MW-1];
               r_s1_lz    <= w_lz_count;
            end
         end
         if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
               r_out_sign <= r_s1_sign;
               r_out_exp  <= w_nxt_exp;
               r_out_mant <= w_nxt_mant;
               r_out_zero <= w_nxt_zero;
               r_out_ovf  <= w_nxt_ovf;
            end
         end
      end
   end

   assign out_valid = r_s2_valid;
   assign out_sign  = r_out_sign;
   assign out_exp   = r_out_exp;
   assign out_mant  = r_out_mant;
   assign out_zero  = r_out_zero;
   assign out_ovf   = r_out_ovf;

endmodule
